// File: rtl/uart_v2.sv
// UART with parameterised frame format, TX/RX FIFOs and per-entry error tags.
// Define UART_RTS_CTS_EN to add cts_n/rts_n hardware flow control.
module uart_v2 #(
    parameter int CLK_PER_BIT   = 64,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_perr,
    output logic                               rx_ferr,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic                               rx_overrun,
    input  logic                               overrun_clr,
    output logic [$clog2(TX_FIFO_DEPTH):0]     tx_level,
    output logic [$clog2(RX_FIFO_DEPTH):0]     rx_level,
    output logic                               tx_busy,
    output logic                               tx,
    input  logic                               rx
`ifdef UART_RTS_CTS_EN
    ,
    input  logic                               cts_n,
    output logic                               rts_n
`endif
);

    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [TX_FIFO_DEPTH];
    logic [TX_AW-1:0]     tx_wr_ptr;
    logic [TX_AW-1:0]     tx_rd_ptr;
    logic                 tx_push;
    logic                 tx_pop;

    assign tx_ready = (tx_level != (TX_AW+1)'(TX_FIFO_DEPTH));
    assign tx_push  = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= tx_data;
    end

    // Power-of-two depth: natural pointer overflow is the DEPTH-1 -> 0 wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_level <= tx_level + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        end
    end

    // ---------------- flow control ----------------
    logic tx_go;
`ifdef UART_RTS_CTS_EN
    logic cts_p0;
    logic cts_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_p0 <= 1'b1;
            cts_p1 <= 1'b1;
        end else begin
            cts_p0 <= cts_n;
            cts_p1 <= cts_p0;
        end
    end

    assign tx_go = ~cts_p1;
    assign rts_n = (rx_level >= (RX_AW+1)'(RX_FIFO_DEPTH - 2));
`else
    assign tx_go = 1'b1;
`endif

    // ---------------- TX engine ----------------
    logic [2:0]           tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_bit_end;
    logic                 tx_frame_end;

    assign tx_bit_end   = (tx_cnt == BIT_LAST);
    assign tx_frame_end = (tx_state == S_STOP) && tx_bit_end && (tx_idx == STOP_LAST);
    assign tx_pop       = tx_go && (tx_level != '0) && ((tx_state == S_IDLE) || tx_frame_end);
    assign tx_busy      = (tx_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd_ptr];
            tx_par   <= parity_of(tx_mem[tx_rd_ptr]);
        end else if ((tx_state == S_DATA) && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // tx is registered; each new line level is loaded on the bit-boundary edge
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx       <= 1'b1;
        end else if (tx_state == S_IDLE) begin
            tx_cnt <= '0;
            if (tx_pop) begin
                tx_state <= S_START;
                tx       <= 1'b0;
            end
        end else if (!tx_bit_end) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    tx_idx   <= '0;
                    tx       <= tx_shift[0];
                end
                S_DATA: begin
                    if (tx_idx == DATA_LAST) begin
                        tx_idx <= '0;
                        if (PARITY != 0) begin
                            tx_state <= S_PARITY;
                            tx       <= tx_par;
                        end else begin
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
                        end
                    end else begin
                        tx_idx <= tx_idx + 1'b1;
                        tx     <= tx_shift[1];
                    end
                end
                S_PARITY: begin
                    tx_state <= S_STOP;
                    tx_idx   <= '0;
                    tx       <= 1'b1;
                end
                S_STOP: begin
                    if (tx_idx != STOP_LAST) begin
                        tx_idx <= tx_idx + 1'b1;
                    end else if (tx_pop) begin
                        tx_state <= S_START;
                        tx       <= 1'b0;
                    end else begin
                        tx_state <= S_IDLE;
                        tx       <= 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX synchroniser ----------------
    logic rx_p0;
    logic rx_p1;
    logic rx_p2;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign rx_fall = rx_p2 & ~rx_p1;

    // ---------------- RX engine ----------------
    logic [2:0]           rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_s;
    logic                 rx_bit_end;
    logic                 rx_push_req;
    logic                 rx_perr_new;

    assign rx_bit_end  = (rx_cnt == BIT_LAST);
    assign rx_push_req = (rx_state == S_STOP) && rx_bit_end;
    assign rx_perr_new = (PARITY != 0) && (rx_par_s != parity_of(rx_shift));

    always_ff @(posedge clk) begin
        if ((rx_state == S_DATA) && rx_bit_end)
            rx_shift <= {rx_p1, rx_shift[DATA_BITS-1:1]};
        if ((rx_state == S_PARITY) && rx_bit_end)
            rx_par_s <= rx_p1;
    end

    // After the start-bit midpoint every sample lands one full bit later
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall)
                        rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_p1 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_idx == DATA_LAST)
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            rx_idx <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY, S_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= (rx_state == S_PARITY) ? S_STOP : S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS+1:0] rx_mem [RX_FIFO_DEPTH];
    logic [RX_AW-1:0]     rx_wr_ptr;
    logic [RX_AW-1:0]     rx_rd_ptr;
    logic                 rx_full;
    logic                 rx_push;
    logic                 rx_pop;

    assign rx_full  = (rx_level == (RX_AW+1)'(RX_FIFO_DEPTH));
    assign rx_valid = (rx_level != '0);
    assign rx_push  = rx_push_req & ~rx_full;
    assign rx_pop   = rx_ready & rx_valid;
    assign {rx_perr, rx_ferr, rx_data} = rx_mem[rx_rd_ptr];

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= {rx_perr_new, ~rx_p1, rx_shift};
    end

    // Fullness is judged before any same-cycle pop, so a pop cannot save the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_level   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_level <= rx_level + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
            if (rx_push_req && rx_full)
                rx_overrun <= 1'b1;
            else if (overrun_clr)
                rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_v2.sv
// Directed bench for uart_v2: loopback, FIFO limits, parity/framing tags, overrun, reset.
module tb_uart_v2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // u_a: 8N1, 4-deep FIFOs, optional loopback
    logic       loop_en = 1'b0, rx_drv_a = 1'b1, rx_a;
    logic [7:0] tx_data_a = '0;
    logic       tx_valid_a = 1'b0, rx_ready_a = 1'b0, clr_a = 1'b0;
    logic       a_tx_ready, a_perr, a_ferr, a_rx_valid, a_ovr, a_busy, a_tx;
    logic [7:0] a_rx_data;
    logic [2:0] a_tx_level, a_rx_level;
    assign rx_a = loop_en ? a_tx : rx_drv_a;

    // u_e / u_o: even / odd parity receivers sharing one driven line
    logic       rx_drv_p = 1'b1, rx_ready_p = 1'b0, zero = 1'b0;
    logic [7:0] tx_data_p = '0;
    logic       e_tx_ready, e_perr, e_ferr, e_rx_valid, e_ovr, e_busy, e_tx;
    logic       o_tx_ready, o_perr, o_ferr, o_rx_valid, o_ovr, o_busy, o_tx;
    logic [7:0] e_rx_data, o_rx_data;
    logic [4:0] e_tx_level, e_rx_level, o_tx_level, o_rx_level;
`ifdef UART_RTS_CTS_EN
    logic cts_a = 1'b0;
    logic a_rts, e_rts, o_rts;
`endif

    uart_v2 #(.CLK_PER_BIT(16), .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_perr(a_perr), .rx_ferr(a_ferr), .rx_valid(a_rx_valid),
        .rx_ready(rx_ready_a), .rx_overrun(a_ovr), .overrun_clr(clr_a), .tx_level(a_tx_level),
        .rx_level(a_rx_level), .tx_busy(a_busy), .tx(a_tx), .rx(rx_a)
`ifdef UART_RTS_CTS_EN
        , .cts_n(cts_a), .rts_n(a_rts)
`endif
    );

    uart_v2 #(.CLK_PER_BIT(16), .PARITY(1)) u_e (
        .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(zero), .tx_ready(e_tx_ready),
        .rx_data(e_rx_data), .rx_perr(e_perr), .rx_ferr(e_ferr), .rx_valid(e_rx_valid),
        .rx_ready(rx_ready_p), .rx_overrun(e_ovr), .overrun_clr(zero), .tx_level(e_tx_level),
        .rx_level(e_rx_level), .tx_busy(e_busy), .tx(e_tx), .rx(rx_drv_p)
`ifdef UART_RTS_CTS_EN
        , .cts_n(zero), .rts_n(e_rts)
`endif
    );

    uart_v2 #(.CLK_PER_BIT(16), .PARITY(2)) u_o (
        .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(zero), .tx_ready(o_tx_ready),
        .rx_data(o_rx_data), .rx_perr(o_perr), .rx_ferr(o_ferr), .rx_valid(o_rx_valid),
        .rx_ready(rx_ready_p), .rx_overrun(o_ovr), .overrun_clr(zero), .tx_level(o_tx_level),
        .rx_level(o_rx_level), .tx_busy(o_busy), .tx(o_tx), .rx(rx_drv_p)
`ifdef UART_RTS_CTS_EN
        , .cts_n(zero), .rts_n(o_rts)
`endif
    );

    typedef struct {
        logic       sel_p;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr_e;
        logic       exp_perr_o;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] golden[4];
    int         n_acc;
    logic       seen_full;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic which, input logic b);
        if (which) rx_drv_p = b;
        else rx_drv_a = b;
        repeat (16) tick();
    endtask

    task automatic send_frame(input logic which, input logic [7:0] d, input logic with_par,
                              input logic par, input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (with_par) send_bit(which, par);
        send_bit(which, stop);
        send_bit(which, 1'b1);
    endtask

    task automatic pop_a();
        rx_ready_a = 1'b1;
        tick();
        rx_ready_a = 1'b0;
    endtask

    // One clock of the loopback scoreboard: record accepted pushes, check every pop
    task automatic cycle_a();
        logic acc;
        acc = tx_valid_a && a_tx_ready;
        if (rx_ready_a && a_rx_valid) begin
            chk("lap_q_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("lap_data", a_rx_data, exp_q[0]);
                chk("lap_tags", {a_perr, a_ferr}, 0);
                void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(tx_data_a);
        tick();
        if (acc) begin
            tx_data_a = tx_data_a + 8'd1;
            n_acc++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        golden  = '{8'h55, 8'hA3, 8'h00, 8'hFF};

        // reset state
        repeat (3) tick();
        chk("rst_tx", a_tx, 1);
        chk("rst_tx_ready", a_tx_ready, 1);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_tx_level", a_tx_level, 0);
        chk("rst_rx_level", a_rx_level, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_busy", a_busy, 0);
`ifdef UART_RTS_CTS_EN
        chk("rst_rts", a_rts, 0);
`endif
        rst = 1'b0;
        repeat (5) tick();

        // loopback, four back-to-back frames
        loop_en = 1'b1;
        tx_valid_a = 1'b1;
        tx_data_a = golden[0]; tick();
        chk("lb_level_push", a_tx_level, 1);
        tx_data_a = golden[1]; tick();
        chk("lb_level_push_pop", a_tx_level, 1);
        chk("lb_busy", a_busy, 1);
        tx_data_a = golden[2]; tick();
        tx_data_a = golden[3]; tick();
        tx_valid_a = 1'b0;
        chk("lb_level_3", a_tx_level, 3);
        k = 0;
        while (a_busy && k < 2000) begin tick(); k++; end
        chk("lb_contiguous_cycles", k, 638);
        repeat (20) tick();
        chk("lb_rx_level", a_rx_level, 4);
        chk("lb_overrun", a_ovr, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lb_byte%0d", i), a_rx_data, golden[i]);
            chk($sformatf("lb_tags%0d", i), {a_perr, a_ferr}, 0);
            pop_a();
        end
        chk("lb_rx_empty", a_rx_valid, 0);

        // TX FIFO fill and pointer laps through loopback
        rx_ready_a = 1'b1;
        tx_valid_a = 1'b1;
        tx_data_a = 8'h20;
        n_acc = 0;
        seen_full = 1'b0;
        for (int j = 0; j < 6000 && n_acc < 14; j++) begin
            cycle_a();
            if (!seen_full && a_tx_level == 3'd4) begin
                seen_full = 1'b1;
                chk("full_tx_ready", a_tx_ready, 0);
            end
        end
        tx_valid_a = 1'b0;
        for (int j = 0; j < 4000 && exp_q.size() != 0; j++) cycle_a();
        chk("full_seen", seen_full, 1);
        chk("lap_pushes", n_acc, 14);
        chk("lap_q_drained", exp_q.size(), 0);
        repeat (20) tick();
        chk("lap_rx_level", a_rx_level, 0);
        rx_ready_a = 1'b0;
        loop_en = 1'b0;
        repeat (40) tick();

        // RX overrun: 5 frames into a 4-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b1);
        chk("ovr_level", a_rx_level, 4);
        chk("ovr_flag", a_ovr, 1);
`ifdef UART_RTS_CTS_EN
        chk("ovr_rts", a_rts, 1);
`endif
        clr_a = 1'b1;
        tick();
        chk("ovr_cleared", a_ovr, 0);
        fork
            send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
            begin
                for (int j = 0; j < 400 && !a_ovr; j++) tick();
                clr_a = 1'b0;
            end
        join
        repeat (3) tick();
        chk("ovr_set_wins", a_ovr, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovr_keep%0d", i), a_rx_data, 8'(8'h11 * (i + 1)));
            pop_a();
        end
        chk("ovr_drained", a_rx_level, 0);

        // parity and framing vectors
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].sel_p, vecs[i].data, vecs[i].sel_p, vecs[i].par, vecs[i].stop);
            if (vecs[i].sel_p) begin
                chk($sformatf("v%0d_e_level", i), e_rx_level, 1);
                chk($sformatf("v%0d_e_data", i), e_rx_data, vecs[i].data);
                chk($sformatf("v%0d_e_perr", i), e_perr, vecs[i].exp_perr_e);
                chk($sformatf("v%0d_e_ferr", i), e_ferr, vecs[i].exp_ferr);
                chk($sformatf("v%0d_o_data", i), o_rx_data, vecs[i].data);
                chk($sformatf("v%0d_o_perr", i), o_perr, vecs[i].exp_perr_o);
                chk($sformatf("v%0d_o_ferr", i), o_ferr, vecs[i].exp_ferr);
                rx_ready_p = 1'b1;
                tick();
                rx_ready_p = 1'b0;
            end else begin
                chk($sformatf("v%0d_a_level", i), a_rx_level, 1);
                chk($sformatf("v%0d_a_data", i), a_rx_data, vecs[i].data);
                chk($sformatf("v%0d_a_perr", i), a_perr, vecs[i].exp_perr_e);
                chk($sformatf("v%0d_a_ferr", i), a_ferr, vecs[i].exp_ferr);
                pop_a();
            end
        end

        // 3-cycle low glitch on rx
        rx_drv_a = 1'b0;
        repeat (3) tick();
        rx_drv_a = 1'b1;
        repeat (40) tick();
        chk("glitch_level", a_rx_level, 0);
        chk("glitch_valid", a_rx_valid, 0);

        // reset in the middle of a data bit
        tx_valid_a = 1'b1;
        tx_data_a = 8'h00;
        repeat (3) tick();
        tx_valid_a = 1'b0;
        repeat (30) tick();
        chk("mid_tx_low", a_tx, 0);
        chk("mid_level", a_tx_level, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", a_tx, 1);
        chk("mid_rst_level", a_tx_level, 0);
        chk("mid_rst_busy", a_busy, 0);
        rst = 1'b0;
        repeat (5) tick();

`ifdef UART_RTS_CTS_EN
        cts_a = 1'b1;
        repeat (3) tick();
        tx_valid_a = 1'b1;
        tx_data_a = 8'h5A;
        repeat (2) tick();
        tx_valid_a = 1'b0;
        repeat (20) tick();
        chk("cts_hold_tx", a_tx, 1);
        chk("cts_hold_level", a_tx_level, 2);
        chk("cts_hold_busy", a_busy, 0);
        cts_a = 1'b0;
        k = 0;
        while (a_tx && k < 10) begin tick(); k++; end
        chk("cts_start_latency", 32'(k <= 3), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
